// File: rtl/im_ctrl_pkg.sv
// Shared text-segment address constants for the instruction-memory controller.
package im_ctrl_pkg;

    localparam logic [31:0] TEXT_START  = 32'h0000_3000;
    localparam int          DEPTH_WORDS = 4096;
    localparam int          ADDR_W      = $clog2(DEPTH_WORDS);

endpackage

// File: rtl/im_if.sv
// Fetch, loader and BRAM signals of the instruction-memory controller.
interface im_if
    import im_ctrl_pkg::*;
#(
    parameter int AW = ADDR_W
);
    logic          f_req;
    logic [31:0]   f_addr;
    logic          f_ready;
    logic          f_valid;
    logic [31:0]   f_instr;
    logic          f_fault;
    logic          f_flush;
    logic          load_mode;
    logic          l_req;
    logic [31:0]   l_addr;
    logic [31:0]   l_data;
    logic          l_ack;
    logic          l_err;
    logic [15:0]   load_count;
    logic          bram_en;
    logic [3:0]    bram_we;
    logic [AW-1:0] bram_addr;
    logic [31:0]   bram_din;
    logic [31:0]   bram_dout;

    modport slave (
        input  f_req, f_addr, load_mode, l_req, l_addr, l_data, bram_dout,
        output f_ready, f_valid, f_instr, f_fault, f_flush, l_ack, l_err,
               load_count, bram_en, bram_we, bram_addr, bram_din
    );

    modport master (
        output f_req, f_addr, load_mode, l_req, l_addr, l_data, bram_dout,
        input  f_ready, f_valid, f_instr, f_fault, f_flush, l_ack, l_err,
               load_count, bram_en, bram_we, bram_addr, bram_din
    );
endinterface

// File: rtl/im_addr_chk.sv
// Combinational legality check and byte-address to BRAM word-index translation.
module im_addr_chk
    import im_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE  = TEXT_START,
    parameter int          DEPTH = DEPTH_WORDS,
    parameter int          AW    = ADDR_W
) (
    input  logic [31:0]   addr,
    output logic          legal,
    output logic [AW-1:0] idx
);
    logic [31:0] off;

    // The lower-bound test guards the subtraction, so wrapped offsets never pass.
    assign off   = addr - BASE;
    assign legal = (addr[1:0] == 2'b00) && (addr >= BASE) && (off < 32'(DEPTH * 4));
    assign idx   = off[AW+1:2];
endmodule

// File: rtl/im_ctrl.sv
// Instruction-memory controller: arbitrates the single BRAM port between fetch
// and loader writes, and hides the BRAM's one-cycle read latency.
module im_ctrl
    import im_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    im_if.slave  bus
);
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic                f_legal, l_legal;
    logic [ADDR_W-1:0]   f_idx, l_idx;
    logic                f_acc, l_acc;
    logic [31:0]         f_instr_q;

    im_addr_chk u_fetch_chk (.addr(bus.f_addr), .legal(f_legal), .idx(f_idx));
    im_addr_chk u_load_chk  (.addr(bus.l_addr), .legal(l_legal), .idx(l_idx));

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt     = state;
        bus.f_ready   = 1'b0;
        bus.l_ack     = 1'b0;
        bus.f_flush   = 1'b0;
        case (state)
            RUN: begin
                bus.f_ready = ~bus.load_mode;
                if (bus.load_mode) state_nxt = LOAD;
            end
            LOAD: begin
                bus.l_ack = bus.l_req;
                if (!bus.load_mode) state_nxt = FLUSH;
            end
            FLUSH: begin
                bus.f_flush = 1'b1;
                state_nxt   = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    assign f_acc         = bus.f_ready & bus.f_req;
    assign l_acc         = bus.l_ack;
    assign bus.bram_en   = (f_acc & f_legal) | (l_acc & l_legal);
    assign bus.bram_we   = (l_acc & l_legal) ? 4'hF : 4'h0;
    assign bus.bram_addr = l_acc ? l_idx : f_idx;
    assign bus.bram_din  = bus.l_data;

    // Bram_Dout is live only in the cycle after a read; outside it the last
    // returned word is replayed from f_instr_q.
    assign bus.f_instr = bus.f_valid ? (bus.f_fault ? 32'h0 : bus.bram_dout) : f_instr_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= RUN;
            bus.f_valid    <= 1'b0;
            bus.f_fault    <= 1'b0;
            bus.l_err      <= 1'b0;
            bus.load_count <= 16'h0;
            f_instr_q      <= 32'h0;
        end else begin
            state       <= state_nxt;
            bus.f_valid <= f_acc;
            bus.f_fault <= f_acc & ~f_legal;
            bus.l_err   <= l_acc & ~l_legal;
            if (bus.f_valid) f_instr_q <= bus.f_instr;
            if (state == RUN && state_nxt == LOAD)
                bus.load_count <= 16'h0;
            else if (l_acc && l_legal && bus.load_count != 16'hFFFF)
                bus.load_count <= bus.load_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_im_ctrl.sv
// Directed self-checking bench for im_ctrl with a behavioural registered-read BRAM.
module tb_im_ctrl;
    import im_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    logic preload;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] dout_q;

    im_if bus ();

    im_ctrl dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    // Behavioural BRAM: registered read, output holds when disabled or writing.
    always @(posedge clk) begin
        if (preload) begin
            mem[0] <= 32'h1111_1111;
            mem[1] <= 32'h2222_2222;
            mem[2] <= 32'h3333_3333;
        end else if (bus.bram_en) begin
            if (bus.bram_we == 4'hF) mem[bus.bram_addr] <= bus.bram_din;
            else                     dout_q <= mem[bus.bram_addr];
        end
    end
    assign bus.bram_dout = dout_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] fault_addr [3];

    initial begin
        fault_addr[0] = 32'h0000_3002;
        fault_addr[1] = 32'h0000_2FFC;
        fault_addr[2] = 32'h0000_7000;

        reset_n       = 1'b0;
        preload       = 1'b1;
        bus.f_req     = 1'b0;
        bus.f_addr    = 32'h0;
        bus.load_mode = 1'b0;
        bus.l_req     = 1'b0;
        bus.l_addr    = 32'h0;
        bus.l_data    = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        preload = 1'b0;
        check("rst_f_valid", 32'(bus.f_valid), 32'h0);
        check("rst_f_fault", 32'(bus.f_fault), 32'h0);
        check("rst_f_flush", 32'(bus.f_flush), 32'h0);
        check("rst_l_err", 32'(bus.l_err), 32'h0);
        check("rst_load_count", 32'(bus.load_count), 32'h0);
        check("rst_f_instr", bus.f_instr, 32'h0);
        check("rst_bram_en", 32'(bus.bram_en), 32'h0);
        check("rst_bram_we", 32'(bus.bram_we), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // Back-to-back legal fetches
        bus.f_req  = 1'b1;
        bus.f_addr = 32'h0000_3000;
        #1;
        check("fetch0_ready", 32'(bus.f_ready), 32'h1);
        check("fetch0_en", 32'(bus.bram_en), 32'h1);
        check("fetch0_addr", 32'(bus.bram_addr), 32'h0);
        step();
        bus.f_addr = 32'h0000_3004;
        #1;
        check("fetch0_valid", 32'(bus.f_valid), 32'h1);
        check("fetch0_instr", bus.f_instr, 32'h1111_1111);
        check("fetch1_addr", 32'(bus.bram_addr), 32'h1);
        step();
        check("fetch1_valid", 32'(bus.f_valid), 32'h1);
        check("fetch1_fault", 32'(bus.f_fault), 32'h0);
        check("fetch1_instr", bus.f_instr, 32'h2222_2222);

        // Misaligned, below-base and past-end fetches
        for (int i = 0; i < 3; i++) begin
            bus.f_addr = fault_addr[i];
            #1;
            check("fault_en", 32'(bus.bram_en), 32'h0);
            step();
            check("fault_valid", 32'(bus.f_valid), 32'h1);
            check("fault_flag", 32'(bus.f_fault), 32'h1);
            check("fault_instr", bus.f_instr, 32'h0);
        end

        // Last word of the segment maps to the top index
        bus.f_addr = 32'h0000_6FFC;
        #1;
        check("top_en", 32'(bus.bram_en), 32'h1);
        check("top_idx", 32'(bus.bram_addr), 32'h0000_0FFF);
        bus.f_req = 1'b0;
        step();
        check("idle_valid", 32'(bus.f_valid), 32'h0);
        check("idle_instr_hold", bus.f_instr, 32'h0);

        // Load session: L_Req seen with Load_Mode in RUN is not yet acknowledged
        bus.load_mode = 1'b1;
        bus.l_req     = 1'b1;
        bus.l_addr    = 32'h0000_3000;
        bus.l_data    = 32'hDEAD_BEEF;
        #1;
        check("ld_run_ready", 32'(bus.f_ready), 32'h0);
        check("ld_run_ack", 32'(bus.l_ack), 32'h0);
        check("ld_run_en", 32'(bus.bram_en), 32'h0);
        step();
        check("ld_ack0", 32'(bus.l_ack), 32'h1);
        check("ld_we0", 32'(bus.bram_we), 32'hF);
        check("ld_din0", bus.bram_din, 32'hDEAD_BEEF);
        check("ld_count0", 32'(bus.load_count), 32'h0);
        step();
        bus.l_addr = 32'h0000_3004;
        bus.l_data = 32'h2408_0001;
        #1;
        check("ld_addr1", 32'(bus.bram_addr), 32'h1);
        step();
        bus.l_addr = 32'h0000_3001;
        bus.l_data = 32'h5555_5555;
        #1;
        check("ld_illegal_ack", 32'(bus.l_ack), 32'h1);
        check("ld_illegal_en", 32'(bus.bram_en), 32'h0);
        step();
        check("ld_err", 32'(bus.l_err), 32'h1);
        check("ld_count2", 32'(bus.load_count), 32'h2);
        bus.l_req     = 1'b0;
        bus.load_mode = 1'b0;
        step();
        check("flush_pulse", 32'(bus.f_flush), 32'h1);
        check("flush_ready", 32'(bus.f_ready), 32'h0);
        check("flush_err_clear", 32'(bus.l_err), 32'h0);
        step();
        check("run_flush_clear", 32'(bus.f_flush), 32'h0);
        check("run_ready", 32'(bus.f_ready), 32'h1);
        check("run_count_hold", 32'(bus.load_count), 32'h2);

        bus.f_req  = 1'b1;
        bus.f_addr = 32'h0000_3000;
        step();
        bus.f_addr = 32'h0000_3004;
        check("reload_instr0", bus.f_instr, 32'hDEAD_BEEF);
        step();
        check("reload_instr1", bus.f_instr, 32'h2408_0001);

        // Preempt: Load_Mode rises with a fetch in flight
        bus.f_addr = 32'h0000_3008;
        step();
        bus.load_mode = 1'b1;
        bus.l_req     = 1'b1;
        bus.l_addr    = 32'h0000_3010;
        bus.l_data    = 32'hA000_0000;
        #1;
        check("pre_valid", 32'(bus.f_valid), 32'h1);
        check("pre_instr", bus.f_instr, 32'h3333_3333);
        check("pre_ready", 32'(bus.f_ready), 32'h0);
        check("pre_ack", 32'(bus.l_ack), 32'h0);
        check("pre_en", 32'(bus.bram_en), 32'h0);
        step();
        check("pre_load_valid", 32'(bus.f_valid), 32'h0);
        check("pre_load_ack", 32'(bus.l_ack), 32'h1);
        check("pre_load_ready", 32'(bus.f_ready), 32'h0);
        step();
        bus.l_addr = 32'h0000_3014;
        bus.l_data = 32'hA000_0001;
        step();
        bus.l_addr = 32'h0000_3018;
        bus.l_data = 32'hA000_0002;
        step();
        check("pre_count3", 32'(bus.load_count), 32'h3);

        // Asynchronous reset in the middle of LOAD
        reset_n       = 1'b0;
        bus.load_mode = 1'b0;
        bus.l_req     = 1'b0;
        bus.f_req     = 1'b0;
        #1;
        check("arst_count", 32'(bus.load_count), 32'h0);
        check("arst_valid", 32'(bus.f_valid), 32'h0);
        check("arst_run", 32'(bus.f_ready), 32'h1);
        check("arst_ack", 32'(bus.l_ack), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        bus.f_req  = 1'b1;
        bus.f_addr = 32'h0000_3010;
        step();
        bus.f_addr = 32'h0000_3014;
        check("arst_word0", bus.f_instr, 32'hA000_0000);
        step();
        bus.f_addr = 32'h0000_3018;
        check("arst_word1", bus.f_instr, 32'hA000_0001);
        step();
        bus.f_req = 1'b0;
        check("arst_word2", bus.f_instr, 32'hA000_0002);

        // Load_Mode toggles 1 -> 0 -> 1
        bus.load_mode = 1'b1;
        step();
        bus.load_mode = 1'b0;
        step();
        check("tog_flush", 32'(bus.f_flush), 32'h1);
        bus.load_mode = 1'b1;
        bus.l_req     = 1'b1;
        bus.l_addr    = 32'h0000_3000;
        bus.l_data    = 32'h0;
        #1;
        check("tog_flush_ack", 32'(bus.l_ack), 32'h0);
        step();
        check("tog_run_ready", 32'(bus.f_ready), 32'h0);
        check("tog_run_flush", 32'(bus.f_flush), 32'h0);
        check("tog_run_ack", 32'(bus.l_ack), 32'h0);
        step();
        check("tog_load_ack", 32'(bus.l_ack), 32'h1);
        check("tog_load_count", 32'(bus.load_count), 32'h0);

        // Saturation of Load_Count
        for (int i = 0; i < 65540; i++) begin
            bus.l_addr = TEXT_START + 32'((i % DEPTH_WORDS) * 4);
            bus.l_data = 32'(i);
            step();
        end
        check("sat_count", 32'(bus.load_count), 32'h0000_FFFF);
        bus.l_req     = 1'b0;
        bus.load_mode = 1'b0;
        step();
        step();
        check("sat_hold_run", 32'(bus.load_count), 32'h0000_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
